// File: rtl/pepper_spi_pkg.sv
// Shared definitions for the SPI Mode 3 slave: default word width,
// synchronizer depth and the frame state encoding.
package pepper_spi_pkg;

  localparam int DEF_WORD_W      = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for one asynchronous pad input, plus one extra
// registered copy so the consumer can detect edges (q vs q_d).
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_d
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking would collapse
  // the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI Mode 3 slave: oversamples CS/SCK/MOSI in the clk domain, assembles
// MSB-first words and shifts a response word out on MISO in the same frame.
module spi_slave_if
  import pepper_spi_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  output logic              tx_load,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic cs_s, cs_d, sck_s, sck_d, mosi_s, mosi_unused_d;

  // CS resets to "asserted" so a frame already running when reset releases
  // never produces a cs_fall; the block waits for a fresh frame instead.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(CS), .q(cs_s), .q_d(cs_d)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(SCK), .q(sck_s), .q_d(sck_d)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s), .q_d(mosi_unused_d)
  );

  logic cs_fall, cs_rise, sck_rise;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = cs_s & ~cs_d;
  assign sck_rise = sck_s & ~sck_d;

  state_t            state, state_next;
  logic [CNT_W-1:0]  bit_cnt, cnt_next;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-2:0] rx_shift;
  logic              rx_done;
  logic              shift_en, last_rise;

  assign shift_en  = (state == SHIFT) && sck_rise;
  assign last_rise = shift_en && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      IDLE:  if (cs_fall) state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: begin
        cnt_next = bit_cnt;
        if (shift_en) cnt_next = last_rise ? '0 : bit_cnt + CNT_W'(1);
        if (last_rise) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
    // CS release wins over everything, but only after this cycle's SCK
    // rise has been accounted for in cnt_next.
    if (cs_rise) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bit_cnt   <= cs_rise ? '0 : cnt_next;
      rx_done   <= last_rise;
      rx_valid  <= rx_done;
      frame_err <= cs_rise && (cnt_next != '0);
      if (state == LOAD) begin
        tx_shift <= tx_data;
      end else if (shift_en) begin
        rx_shift <= {rx_shift[WORD_W-3:0], mosi_s};
        if (last_rise) rx_data  <= {rx_shift, mosi_s};
        else           tx_shift <= tx_shift << 1;
      end
    end
  end

  // MISO only changes after a detected rise, i.e. after the master sampled.
  assign MISO    = (state == LOAD)  ? tx_data[WORD_W-1]
                 : (state == SHIFT) ? tx_shift[WORD_W-1] : 1'b0;
  assign busy    = (state != IDLE);
  assign miso_oe = busy;
  assign tx_load = (state == LOAD);

endmodule
